// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if
//    Groups the display-data and status signals of the 7-segment scan
//    controller into one bundle.
//    master : the game/timer logic side (drives data, reads status/pins)
//    slave  : the scan controller itself
// Signals:
//    data_in      hex nibbles, [3:0] = digit 0 (rightmost)
//    dp_in        decimal point per digit
//    blank_in     1 = digit dark
//    blink_in     1 = digit blinks
//    load         1-cycle pulse, captures the four inputs above into staging
//    lz_suppress  leading-zero suppression enable (live)
//    brightness   PWM duty, 0 = off, all-ones = full on
//    seg_out      {dp,g,f,e,d,c,b,a} after polarity
//    cs_out       digit select after polarity
//    frame_start  1-cycle pulse in the first cycle of the digit-0 slot
//    update_done  1-cycle pulse when staging has been applied to shadow
interface seg7_scan_ctrl_if #(
   parameter int DIGITS   = 4,
   parameter int BRIGHT_W = 4
);
   logic [4*DIGITS-1:0] data_in;
   logic [DIGITS-1:0]   dp_in;
   logic [DIGITS-1:0]   blank_in;
   logic [DIGITS-1:0]   blink_in;
   logic                load;
   logic                lz_suppress;
   logic [BRIGHT_W-1:0] brightness;
   logic [7:0]          seg_out;
   logic [DIGITS-1:0]   cs_out;
   logic                frame_start;
   logic                update_done;

   modport master (
      output data_in, dp_in, blank_in, blink_in, load, lz_suppress, brightness,
      input  seg_out, cs_out, frame_start, update_done
   );

   modport slave (
      input  data_in, dp_in, blank_in, blink_in, load, lz_suppress, brightness,
      output seg_out, cs_out, frame_start, update_done
   );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
//    Multiplexed 7-segment scan controller. Each digit owns a slot of
//    SCAN_DIV clocks: the first DEAD_CYC clocks keep every select inactive,
//    the rest show the digit, gated by PWM brightness, blank, blink and
//    leading-zero suppression. New display content is staged on load and
//    copied into the shadow set only at the frame boundary (tear-free).
// Ports:
//    clk    system clock
//    rst_n  asynchronous active-low reset
//    bus    seg7_scan_ctrl_if.slave (data/control inputs, pin outputs)
module seg7_scan_ctrl #(
   parameter int DIGITS       = 4,
   parameter int SCAN_DIV     = 50000,
   parameter int DEAD_CYC     = 500,
   parameter int BRIGHT_W     = 4,
   parameter int BLINK_FRAMES = 100,
   parameter bit SEG_ACT_LOW  = 1'b0,
   parameter bit CS_ACT_LOW   = 1'b1
) (
   input logic             clk,
   input logic             rst_n,
   seg7_scan_ctrl_if.slave bus
);
   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DIG_W = $clog2(DIGITS);
   localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [CNT_W-1:0]    SLOT_LAST   = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0]    DEAD_CNT    = CNT_W'(DEAD_CYC);
   localparam logic [DIG_W-1:0]    DIG_LAST    = DIG_W'(DIGITS - 1);
   localparam logic [BLK_W-1:0]    BLK_LAST    = BLK_W'(BLINK_FRAMES - 1);
   localparam logic [BRIGHT_W-1:0] BRIGHT_FULL = {BRIGHT_W{1'b1}};
   localparam logic [7:0]          SEG_IDLE    = {8{SEG_ACT_LOW}};
   localparam logic [DIGITS-1:0]   CS_IDLE     = {DIGITS{CS_ACT_LOW}};

   typedef enum logic {
      PH_DEAD = 1'b0,
      PH_ON   = 1'b1
   } phase_e;

   // Hex font, bit order {g,f,e,d,c,b,a}.
   function automatic logic [6:0] hex_font(input logic [3:0] nib);
      logic [6:0] f;
      case (nib)
         4'h0:    f = 7'h3F;
         4'h1:    f = 7'h06;
         4'h2:    f = 7'h5B;
         4'h3:    f = 7'h4F;
         4'h4:    f = 7'h66;
         4'h5:    f = 7'h6D;
         4'h6:    f = 7'h7D;
         4'h7:    f = 7'h07;
         4'h8:    f = 7'h7F;
         4'h9:    f = 7'h6F;
         4'hA:    f = 7'h77;
         4'hB:    f = 7'h7C;
         4'hC:    f = 7'h39;
         4'hD:    f = 7'h5E;
         4'hE:    f = 7'h79;
         4'hF:    f = 7'h71;
         default: f = 7'h00;
      endcase
      return f;
   endfunction

   phase_e              phase_q, phase_d;
   logic [CNT_W-1:0]    slot_cnt_q, slot_cnt_d;
   logic [DIG_W-1:0]    digit_q;
   logic [BLK_W-1:0]    blink_cnt_q;
   logic                blink_ph_q;
   logic [BRIGHT_W-1:0] pwm_cnt_q;
   logic [BRIGHT_W-1:0] bright_q;
   logic [4*DIGITS-1:0] stage_data_q, shadow_data_q;
   logic [DIGITS-1:0]   stage_dp_q, shadow_dp_q;
   logic [DIGITS-1:0]   stage_blank_q, shadow_blank_q;
   logic [DIGITS-1:0]   stage_blink_q, shadow_blink_q;
   logic                pending_q;
   logic [7:0]          seg_q, seg_d;
   logic [DIGITS-1:0]   cs_q, cs_d;
   logic                frame_start_q;
   logic                update_done_q;

   logic                slot_last_s;
   logic                frame_end_s;
   logic                upper_nz_s;
   logic                lz_s;
   logic                bright_ok_s;
   logic                lit_s;
   logic [3:0]          nibble_s;

   // Slot timing next-state and the lit decision for the digit in the current cycle.
   always_comb begin
      slot_last_s = (slot_cnt_q == SLOT_LAST);
      frame_end_s = slot_last_s && (digit_q == DIG_LAST);

      if (slot_last_s) begin
         slot_cnt_d = '0;
      end else begin
         slot_cnt_d = slot_cnt_q + CNT_W'(1'b1);
      end

      if (slot_cnt_d < DEAD_CNT) begin
         phase_d = PH_DEAD;
      end else begin
         phase_d = PH_ON;
      end

      // A digit is a leading zero when it and every higher nibble are zero;
      // blank does not matter here, only the nibble value.
      upper_nz_s = 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
         if ((DIG_W'(k) >= digit_q) && (shadow_data_q[4*k +: 4] != 4'h0)) begin
            upper_nz_s = 1'b1;
         end else begin
            upper_nz_s = upper_nz_s;
         end
      end
      lz_s = bus.lz_suppress && (digit_q != '0) && !upper_nz_s;

      bright_ok_s = (bright_q == BRIGHT_FULL) || (pwm_cnt_q < bright_q);
      nibble_s    = shadow_data_q[{digit_q, 2'b00} +: 4];
      lit_s       = (phase_q == PH_ON) && bright_ok_s && !shadow_blank_q[digit_q] &&
                    !(shadow_blink_q[digit_q] && blink_ph_q) && !lz_s;

      if (lit_s) begin
         seg_d = {shadow_dp_q[digit_q], hex_font(nibble_s)} ^ SEG_IDLE;
         cs_d  = (DIGITS'(1'b1) << digit_q) ^ CS_IDLE;
      end else begin
         seg_d = SEG_IDLE;
         cs_d  = CS_IDLE;
      end
   end

   // Slot FSM, frame/blink bookkeeping, staging/shadow transfer and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q        <= PH_DEAD;
         slot_cnt_q     <= '0;
         digit_q        <= '0;
         blink_cnt_q    <= '0;
         blink_ph_q     <= 1'b0;
         pwm_cnt_q      <= '0;
         bright_q       <= '0;
         stage_data_q   <= '0;
         stage_dp_q     <= '0;
         stage_blank_q  <= '1;
         stage_blink_q  <= '0;
         shadow_data_q  <= '0;
         shadow_dp_q    <= '0;
         shadow_blank_q <= '1;
         shadow_blink_q <= '0;
         pending_q      <= 1'b0;
         seg_q          <= SEG_IDLE;
         cs_q           <= CS_IDLE;
         frame_start_q  <= 1'b0;
         update_done_q  <= 1'b0;
      end else begin
         phase_q    <= phase_d;
         slot_cnt_q <= slot_cnt_d;
         pwm_cnt_q  <= pwm_cnt_q + BRIGHT_W'(1'b1);

         // Brightness is latched for the whole of the next slot.
         if (slot_last_s) begin
            bright_q <= bus.brightness;
            if (digit_q == DIG_LAST) begin
               digit_q <= '0;
            end else begin
               digit_q <= digit_q + DIG_W'(1'b1);
            end
         end

         frame_start_q <= frame_end_s;
         update_done_q <= frame_end_s && pending_q;

         if (frame_end_s) begin
            if (blink_cnt_q == BLK_LAST) begin
               blink_cnt_q <= '0;
               blink_ph_q  <= ~blink_ph_q;
            end else begin
               blink_cnt_q <= blink_cnt_q + BLK_W'(1'b1);
            end
            if (pending_q) begin
               shadow_data_q  <= stage_data_q;
               shadow_dp_q    <= stage_dp_q;
               shadow_blank_q <= stage_blank_q;
               shadow_blink_q <= stage_blink_q;
            end
         end

         // A load coinciding with the boundary re-arms pending for the next frame.
         if (bus.load) begin
            stage_data_q  <= bus.data_in;
            stage_dp_q    <= bus.dp_in;
            stage_blank_q <= bus.blank_in;
            stage_blink_q <= bus.blink_in;
            pending_q     <= 1'b1;
         end else if (frame_end_s) begin
            pending_q <= 1'b0;
         end

         seg_q <= seg_d;
         cs_q  <= cs_d;
      end
   end

   assign bus.seg_out     = seg_q;
   assign bus.cs_out      = cs_q;
   assign bus.frame_start = frame_start_q;
   assign bus.update_done = update_done_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl
//    Randomised self-checking bench for seg7_scan_ctrl with a small geometry
//    (4 digits, 8-clock slots, 2 dead clocks, 2-bit brightness, 2-frame blink).
//    The reference model derives slot position, digit, PWM count and blink
//    phase from a cycle count since reset, and keeps staging/shadow copies
//    that move at frame boundaries.
module tb_seg7_scan_ctrl;
   localparam logic [6:0] FONT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   seg7_scan_ctrl_if #(.DIGITS(4), .BRIGHT_W(2)) bus ();

   seg7_scan_ctrl #(
      .DIGITS(4), .SCAN_DIV(8), .DEAD_CYC(2), .BRIGHT_W(2), .BLINK_FRAMES(2),
      .SEG_ACT_LOW(1'b0), .CS_ACT_LOW(1'b1)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // reference model state
   int unsigned mt;
   int unsigned mbright;
   logic [15:0] st_data, sh_data;
   logic [3:0]  st_dp, st_blank, st_blink, sh_dp, sh_blank, sh_blink;
   logic        pend;
   logic [7:0]  exp_seg;
   logic [3:0]  exp_cs;
   logic        exp_fs, exp_ud;

   task automatic model_reset();
      mt = 0; mbright = 0; pend = 1'b0;
      st_data = 16'h0; st_dp = 4'h0; st_blank = 4'hF; st_blink = 4'h0;
      sh_data = 16'h0; sh_dp = 4'h0; sh_blank = 4'hF; sh_blink = 4'h0;
      exp_seg = 8'h00; exp_cs = 4'hF; exp_fs = 1'b0; exp_ud = 1'b0;
   endtask

   // Advance one clock: expected pins after this edge follow the state before it.
   task automatic tick();
      int   dig;
      logic lit, lz;
      @(posedge clk);
      dig = (mt / 8) % 4;
      lz  = bus.lz_suppress && (dig != 0) && ((sh_data >> (4 * dig)) == 16'h0000);
      lit = ((mt % 8) >= 2) && (mbright == 3 || (mt % 4) < mbright) && !sh_blank[dig] &&
            !(sh_blink[dig] && ((mt / 64) % 2 == 1)) && !lz;
      exp_seg = lit ? {sh_dp[dig], FONT[sh_data[4*dig +: 4]]} : 8'h00;
      exp_cs  = lit ? ~(4'b0001 << dig) : 4'hF;
      exp_fs  = ((mt % 32) == 31);
      exp_ud  = exp_fs && pend;
      if (exp_fs && pend) begin
         sh_data = st_data; sh_dp = st_dp; sh_blank = st_blank; sh_blink = st_blink;
         pend = 1'b0;
      end
      if (bus.load) begin
         st_data = bus.data_in; st_dp = bus.dp_in; st_blank = bus.blank_in; st_blink = bus.blink_in;
         pend = 1'b1;
      end
      if ((mt % 8) == 7) mbright = int'(bus.brightness);
      mt++;
      @(negedge clk);
      bus.load = 1'b0;
   endtask

   task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl,
                          input logic [3:0] bk);
      bus.data_in = d; bus.dp_in = dp; bus.blank_in = bl; bus.blink_in = bk; bus.load = 1'b1;
   endtask

   task automatic test_reset();
      int fs_cnt = 0;
      repeat (3) @(negedge clk);
      if (bus.cs_out !== 4'hF) begin errors++; $display("FAIL reset_cs got %h exp %h", bus.cs_out, 4'hF); end
      checks++;
      if (bus.seg_out !== 8'h00) begin errors++; $display("FAIL reset_seg got %h exp %h", bus.seg_out, 8'h00); end
      checks++;
      if ({bus.frame_start, bus.update_done} !== 2'b00) begin
         errors++; $display("FAIL reset_pulses got %b exp 00", {bus.frame_start, bus.update_done});
      end
      checks++;
      rst_n = 1'b1;
      model_reset();
      repeat (96) begin
         tick();
         if (bus.frame_start === 1'b1) fs_cnt++;
         if (bus.seg_out !== exp_seg || bus.cs_out !== exp_cs || bus.frame_start !== exp_fs || bus.update_done !== exp_ud) begin
            errors++; $display("FAIL dark_frames t=%0d seg %h/%h cs %h/%h fs %b/%b ud %b/%b", mt, bus.seg_out, exp_seg, bus.cs_out, exp_cs, bus.frame_start, exp_fs, bus.update_done, exp_ud);
         end
         checks++;
      end
      if (fs_cnt != 3) begin errors++; $display("FAIL frame_start_count got %0d exp 3", fs_cnt); end
      checks++;
   endtask

   task automatic test_display();
      bus.brightness = 2'd3; bus.lz_suppress = 1'b0;
      do_load(16'h12AF, 4'h0, 4'h0, 4'h0);
      repeat (96) begin
         tick();
         if (bus.seg_out !== exp_seg || bus.cs_out !== exp_cs || bus.frame_start !== exp_fs || bus.update_done !== exp_ud) begin
            errors++; $display("FAIL display t=%0d seg %h/%h cs %h/%h fs %b/%b ud %b/%b", mt, bus.seg_out, exp_seg, bus.cs_out, exp_cs, bus.frame_start, exp_fs, bus.update_done, exp_ud);
         end
         checks++;
      end
   endtask

   task automatic test_pwm();
      bus.brightness = 2'd1;
      do_load(16'h0000, 4'h1, 4'h0, 4'h0);
      for (int i = 0; i < 128; i++) begin
         if (i == 64) bus.brightness = 2'd0;
         tick();
         if (bus.seg_out !== exp_seg || bus.cs_out !== exp_cs || bus.frame_start !== exp_fs || bus.update_done !== exp_ud) begin
            errors++; $display("FAIL pwm t=%0d seg %h/%h cs %h/%h fs %b/%b ud %b/%b", mt, bus.seg_out, exp_seg, bus.cs_out, exp_cs, bus.frame_start, exp_fs, bus.update_done, exp_ud);
         end
         checks++;
      end
   endtask

   task automatic test_lz();
      bus.brightness = 2'd3; bus.lz_suppress = 1'b1;
      do_load(16'h0050, 4'h0, 4'h0, 4'h0);
      for (int i = 0; i < 128; i++) begin
         if (i == 64) do_load(16'h0000, 4'h0, 4'h0, 4'h0);
         tick();
         if (bus.seg_out !== exp_seg || bus.cs_out !== exp_cs || bus.frame_start !== exp_fs || bus.update_done !== exp_ud) begin
            errors++; $display("FAIL lz t=%0d seg %h/%h cs %h/%h fs %b/%b ud %b/%b", mt, bus.seg_out, exp_seg, bus.cs_out, exp_cs, bus.frame_start, exp_fs, bus.update_done, exp_ud);
         end
         checks++;
      end
      bus.lz_suppress = 1'b0;
   endtask

   task automatic test_blink();
      do_load(16'($urandom), 4'($urandom), 4'h0, 4'b0001);
      repeat (256) begin
         tick();
         if (bus.seg_out !== exp_seg || bus.cs_out !== exp_cs || bus.frame_start !== exp_fs || bus.update_done !== exp_ud) begin
            errors++; $display("FAIL blink t=%0d seg %h/%h cs %h/%h fs %b/%b ud %b/%b", mt, bus.seg_out, exp_seg, bus.cs_out, exp_cs, bus.frame_start, exp_fs, bus.update_done, exp_ud);
         end
         checks++;
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 40 && (mt % 32) != 0; i++) tick();
      for (int i = 0; i < 128; i++) begin
         if (i == 5)  do_load(16'($urandom), 4'h2, 4'h0, 4'h0);
         if (i == 10) do_load(16'($urandom), 4'h4, 4'h0, 4'h0);
         if (i == 31) do_load(16'($urandom), 4'h8, 4'h0, 4'h0);
         tick();
         if (bus.seg_out !== exp_seg || bus.cs_out !== exp_cs || bus.frame_start !== exp_fs || bus.update_done !== exp_ud) begin
            errors++; $display("FAIL back_to_back t=%0d seg %h/%h cs %h/%h fs %b/%b ud %b/%b", mt, bus.seg_out, exp_seg, bus.cs_out, exp_cs, bus.frame_start, exp_fs, bus.update_done, exp_ud);
         end
         checks++;
      end
   endtask

   task automatic test_random();
      repeat (640) begin
         if ($urandom_range(39, 0) == 0)
            do_load(16'($urandom), 4'($urandom), 4'($urandom_range(3, 0) == 0 ? $urandom : 0), 4'($urandom));
         if ($urandom_range(59, 0) == 0) bus.brightness = 2'($urandom_range(3, 0));
         if ($urandom_range(99, 0) == 0) bus.lz_suppress = ~bus.lz_suppress;
         tick();
         if (bus.seg_out !== exp_seg || bus.cs_out !== exp_cs || bus.frame_start !== exp_fs || bus.update_done !== exp_ud) begin
            errors++; $display("FAIL random t=%0d seg %h/%h cs %h/%h fs %b/%b ud %b/%b", mt, bus.seg_out, exp_seg, bus.cs_out, exp_cs, bus.frame_start, exp_fs, bus.update_done, exp_ud);
         end
         checks++;
      end
   endtask

   task automatic test_reset_midslot();
      bit found = 1'b0;
      bus.brightness = 2'd3; bus.lz_suppress = 1'b0;
      do_load(16'h8888, 4'hF, 4'h0, 4'h0);
      for (int i = 0; i < 96 && !found; i++) begin
         tick();
         if (mt > 40 && exp_cs != 4'hF) found = 1'b1;
      end
      if (!found || bus.cs_out === 4'hF) begin
         errors++; $display("FAIL midslot_lit got cs %h exp lit digit before reset", bus.cs_out);
      end
      checks++;
      #2 rst_n = 1'b0;
      #1;
      if (bus.cs_out !== 4'hF || bus.seg_out !== 8'h00) begin
         errors++; $display("FAIL midslot_reset got cs %h seg %h exp cs f seg 00", bus.cs_out, bus.seg_out);
      end
      checks++;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      repeat (40) begin
         tick();
         if (bus.seg_out !== exp_seg || bus.cs_out !== exp_cs || bus.frame_start !== exp_fs || bus.update_done !== exp_ud) begin
            errors++; $display("FAIL after_reset t=%0d seg %h/%h cs %h/%h fs %b/%b ud %b/%b", mt, bus.seg_out, exp_seg, bus.cs_out, exp_cs, bus.frame_start, exp_fs, bus.update_done, exp_ud);
         end
         checks++;
      end
   endtask

   initial begin
      bus.data_in = 16'h0; bus.dp_in = 4'h0; bus.blank_in = 4'h0; bus.blink_in = 4'h0;
      bus.load = 1'b0; bus.lz_suppress = 1'b0; bus.brightness = 2'd0;
      model_reset();
      test_reset();
      test_display();
      test_pwm();
      test_lz();
      test_blink();
      test_back_to_back();
      test_random();
      test_reset_midslot();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
